perif_fifo_send: RTL

//  Byte-serialising transmit FIFO for SPI/UART-class peripherals. The CPU writes 1/2/4/8 bytes per IO

---
 rtl/perif_fifo_pkg.sv | 19 +
 rtl/perif_fifo_byte_ram.sv | 29 ++
 rtl/perif_fifo_send.sv | 104 ++++++++++
 3 files changed

// File: rtl/perif_fifo_pkg.sv
// rtl/perif_fifo_pkg.sv - write-size encodings and byte-count helper for the transmit FIFO
package perif_fifo_pkg;

    localparam logic [3:0] CWrSize1 = 4'b0001;
    localparam logic [3:0] CWrSize2 = 4'b0010;
    localparam logic [3:0] CWrSize4 = 4'b0100;
    localparam logic [3:0] CWrSize8 = 4'b1000;
    localparam int         CFreeSat = 8;

    // Highest set request bit wins so a multi-hot request still maps to one size.
    function automatic logic [3:0] FifoWrBytes(input logic [3:0] AWrSize);
        if ((AWrSize & CWrSize8) != 4'b0000)      return 4'd8;
        else if ((AWrSize & CWrSize4) != 4'b0000) return 4'd4;
        else if ((AWrSize & CWrSize2) != 4'b0000) return 4'd2;
        else if ((AWrSize & CWrSize1) != 4'b0000) return 4'd1;
        else                                      return 4'd0;
    endfunction

endpackage

// File: rtl/perif_fifo_byte_ram.sv
// rtl/perif_fifo_byte_ram.sv - byte-wide flop array with eight write lanes and one async read port
module perif_fifo_byte_ram #(
    parameter int CAddrLen = 5
) (
    input  logic                AClkH,
    input  logic                AWrEn,
    input  logic [CAddrLen-1:0] AWrAddr,
    input  logic [3:0]          AWrBytes,
    input  logic [63:0]         AWrData,
    input  logic [CAddrLen-1:0] ARdAddr,
    output logic [7:0]          ARdData
);

    logic [7:0] mem [2**CAddrLen];

    // Lane i lands at AWrAddr+i; the address add wraps naturally at the depth.
    always_ff @(posedge AClkH) begin
        if (AWrEn) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < AWrBytes) begin
                    mem[AWrAddr + CAddrLen'(i)] <= AWrData[8*i +: 8];
                end
            end
        end
    end

    assign ARdData = mem[ARdAddr];

endmodule

// File: rtl/perif_fifo_send.sv
// rtl/perif_fifo_send.sv - byte-serialising transmit FIFO; PERIF_FIFO_SEND_OVF_EN enables sticky overflow flag
module perif_fifo_send
    import perif_fifo_pkg::*;
#(
    parameter int CAddrLen = 5
) (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic [63:0] ADataI,
    input  logic [3:0]  AWrSize,
    output logic [7:0]  ADataO,
    input  logic        ARdEn,
    input  logic        AClr,
    output logic        AHasData,
    output logic [3:0]  AFreeSize,
    output logic        AOvf,
    output logic [3:0]  ATest
);

    localparam int                 CFillW = CAddrLen + 1;
    localparam logic [CFillW-1:0] CDepth = CFillW'(2**CAddrLen);

    logic [CAddrLen-1:0] wrPtr;
    logic [CAddrLen-1:0] rdPtr;
    logic [CFillW-1:0]   fill;
    logic [CFillW-1:0]   freeCnt;
    logic [3:0]          wrBytes;
    logic                wrAcc;
    logic                popAcc;
    logic                isFull;
    logic                ramWrEn;
    logic [7:0]          ramRd;

    assign wrBytes = FifoWrBytes(AWrSize);
    assign freeCnt = CDepth - fill;
    // Admission uses the fill before this cycle's pop; whole write or nothing.
    assign wrAcc   = (wrBytes != 4'd0) && (CFillW'(wrBytes) <= freeCnt);
    assign popAcc  = ARdEn && (fill != '0);
    assign isFull  = (fill == CDepth);
    assign ramWrEn = AResetHN && AClkHEn && !AClr && wrAcc;

    assign AHasData  = (fill != '0);
    assign ADataO    = AHasData ? ramRd : 8'h00;
    assign AFreeSize = (freeCnt >= CFillW'(CFreeSat)) ? 4'(CFreeSat) : freeCnt[3:0];

    perif_fifo_byte_ram #(
        .CAddrLen(CAddrLen)
    ) uRam (
        .AClkH   (AClkH),
        .AWrEn   (ramWrEn),
        .AWrAddr (wrPtr),
        .AWrBytes(wrBytes),
        .AWrData (ADataI),
        .ARdAddr (rdPtr),
        .ARdData (ramRd)
    );

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            fill  <= '0;
            ATest <= 4'b0000;
        end else if (AClkHEn) begin
            if (AClr) begin
                wrPtr <= '0;
                rdPtr <= '0;
                fill  <= '0;
                ATest <= 4'b0000;
            end else begin
                if (wrAcc) begin
                    wrPtr <= wrPtr + CAddrLen'(wrBytes);
                end
                if (popAcc) begin
                    rdPtr <= rdPtr + CAddrLen'(1);
                end
                fill  <= fill + (wrAcc ? CFillW'(wrBytes) : '0) - CFillW'(popAcc);
                ATest <= {AHasData, isFull, wrAcc, popAcc};
            end
        end
    end

`ifdef PERIF_FIFO_SEND_OVF_EN
    logic ovf;

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            ovf <= 1'b0;
        end else if (AClkHEn) begin
            if (AClr) begin
                ovf <= 1'b0;
            end else if ((AWrSize != 4'b0000) && !wrAcc) begin
                ovf <= 1'b1;
            end
        end
    end

    assign AOvf = ovf;
`else
    assign AOvf = 1'b0;
`endif

endmodule
